// File: rtl/store_buffer_ctrl.sv
// store_buffer_ctrl: store byte-lane formatting, FIFO queueing, req/ack drain and load hazard detect (optional merge: STORE_BUF_COMBINE_EN)
module store_buffer_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_sel,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic        ld_check,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        empty,
  output logic        full
);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t r_state, w_state_nx;
  logic [29:0] r_addr [DEPTH];
  logic [31:0] r_data [DEPTH];
  logic [3:0]  r_be   [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr, w_lidx;
  logic [PTR_W:0]   r_count;
  logic        r_mem_req, w_req_nx, w_load, w_pop, w_push, w_mhit, w_unused;
  logic [29:0] r_mem_addr;
  logic [31:0] r_mem_wdata, w_wdata;
  logic [3:0]  r_mem_be, w_be;
  logic [1:0]  w_a, w_sh;
  assign w_a = st_addr[1:0];
  assign w_sh = 2'd3 - w_a;
  assign w_unused = ^ld_addr[1:0];
  assign full = r_count == (PTR_W+1)'(DEPTH);
  assign empty = r_count == '0 && !r_mem_req;
  assign mem_req = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be = r_mem_be;
`ifdef STORE_BUF_COMBINE_EN
  logic [PTR_W-1:0] w_yidx;
  assign w_yidx = r_wptr - PTR_W'(1);
  // youngest entry is mergeable only when it is neither issuing nor about to be loaded for issue
  assign w_mhit = r_count >= (PTR_W+1)'(2) && r_addr[w_yidx] == st_addr[31:2] &&
                  !(r_state == ISSUE && mem_ack && r_count == (PTR_W+1)'(2));
`else
  assign w_mhit = 1'b0;
`endif
  assign st_ready = !full || w_mhit;
  assign w_push = st_valid && st_ready && !w_mhit;
  // big-endian byte enables and lane-aligned data for the incoming store
  always_comb begin
    w_be = 4'b1111;
    w_wdata = st_data;
    case (st_sel)
      3'd0: begin w_be = 4'b1000 >> w_a; w_wdata = {4{st_data[7:0]}}; end
      3'd1: begin w_be = w_a[1] ? 4'b0011 : 4'b1100; w_wdata = {2{st_data[15:0]}}; end
      3'd3: begin w_be = 4'b1111 >> w_a; w_wdata = st_data >> {w_a, 3'b000}; end
      3'd4: begin w_be = 4'b1111 << w_sh; w_wdata = st_data << {w_sh, 3'b000}; end
      default: ;
    endcase
  end
  // word-address match against every valid entry, issuing one included
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (ld_check && {1'b0, PTR_W'(i) - r_rptr} < r_count && r_addr[i] == ld_addr[31:2]) ld_hit = 1'b1;
  end
  // drain FSM next state: issue head, pop on ack, chain back-to-back while entries remain
  always_comb begin
    w_state_nx = r_state;
    w_req_nx = r_mem_req;
    w_load = 1'b0;
    w_pop = 1'b0;
    w_lidx = r_rptr;
    if (r_state == IDLE) begin
      if (r_count != '0) begin w_load = 1'b1; w_req_nx = 1'b1; w_state_nx = ISSUE; end
    end else if (mem_ack) begin
      w_pop = 1'b1;
      w_lidx = r_rptr + PTR_W'(1);
      if (r_count != (PTR_W+1)'(1)) w_load = 1'b1;
      else begin w_req_nx = 1'b0; w_state_nx = IDLE; end
    end
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nx;
  // memory write-port registers, held stable while waiting for ack
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mem_req <= 1'b0;
      r_mem_addr <= '0;
      r_mem_wdata <= '0;
      r_mem_be <= '0;
    end else begin
      r_mem_req <= w_req_nx;
      if (w_load) begin
        r_mem_addr <= r_addr[w_lidx];
        r_mem_wdata <= r_data[w_lidx];
        r_mem_be <= r_be[w_lidx];
      end
    end
  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
    end
  // entry storage; contents only matter while counted as valid
  always_ff @(posedge clk)
    if (w_push) begin
      r_addr[r_wptr] <= st_addr[31:2];
      r_data[r_wptr] <= w_wdata;
      r_be[r_wptr] <= w_be;
    end
`ifdef STORE_BUF_COMBINE_EN
    else if (st_valid && w_mhit) begin
      r_be[w_yidx] <= r_be[w_yidx] | w_be;
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_data[w_yidx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
`endif
endmodule

// File: tb/tb_store_buffer_ctrl.sv
// tb_store_buffer_ctrl: randomized and directed checks of store_buffer_ctrl against a queue-based reference model
module tb_store_buffer_ctrl;
  localparam int DEPTH = 4;
  typedef struct packed {logic [29:0] a; logic [31:0] d; logic [3:0] be;} ent_t;
  logic clk = 0, rst_n = 0, st_valid = 0, st_ready, ld_check = 0, ld_hit, mem_req, mem_ack = 0, empty, full;
  logic [2:0] st_sel = 0;
  logic [31:0] st_addr = 0, st_data = 0, ld_addr = 0, mem_wdata;
  logic [29:0] mem_addr;
  logic [3:0] mem_be;
  int n_chk = 0, n_fail = 0;
  bit run = 0;
  ent_t q[$], wlog[$];
  ent_t m_cur = '0, m_ne;
  bit m_req = 0, m_psh;
  int m_n;
  logic [3:0] t_sb [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0] t_swl [4] = '{4'b1111, 4'b0111, 4'b0011, 4'b0001};
  logic [3:0] t_swr [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};

  store_buffer_ctrl #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready), .st_sel(st_sel),
    .st_addr(st_addr), .st_data(st_data), .ld_check(ld_check), .ld_addr(ld_addr), .ld_hit(ld_hit),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .empty(empty), .full(full));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ent_t form(input logic [2:0] s, input logic [31:0] ad, input logic [31:0] rt);
    ent_t e;
    int a;
    a = int'(ad[1:0]);
    e.a = ad[31:2];
    e.be = 4'hF;
    e.d = rt;
    if (s == 0) begin e.be = t_sb[a]; e.d = {4{rt[7:0]}}; end
    else if (s == 1) begin e.be = (a < 2) ? 4'b1100 : 4'b0011; e.d = {2{rt[15:0]}}; end
    else if (s == 3) begin e.be = t_swl[a]; e.d = rt >> (8 * a); end
    else if (s == 4) begin e.be = t_swr[a]; e.d = rt << (8 * (3 - a)); end
    return e;
  endfunction

  function automatic bit hit();
    foreach (q[i]) if (q[i].a == ld_addr[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  // reference model: pending stores as a queue; head is the one on the write port while m_req
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q.delete();
      m_req = 0;
      m_cur = '0;
    end else begin
      m_n = q.size();
      m_psh = st_valid && m_n < DEPTH;
      m_ne = form(st_sel, st_addr, st_data);
      if (m_req && mem_ack) begin
        void'(q.pop_front());
        if (m_n > 1) m_cur = q[0];
        else m_req = 0;
      end else if (!m_req && m_n != 0) begin
        m_cur = q[0];
        m_req = 1;
      end
      if (m_psh) q.push_back(m_ne);
    end

  always @(negedge clk)
    if (run) begin
      chk("st_ready", 64'(st_ready), 64'(q.size() < DEPTH));
      chk("full", 64'(full), 64'(q.size() == DEPTH));
      chk("empty", 64'(empty), 64'(q.size() == 0 && !m_req));
      chk("mem_req", 64'(mem_req), 64'(m_req));
      chk("mem_addr", 64'(mem_addr), 64'(m_cur.a));
      chk("mem_wdata", 64'(mem_wdata), 64'(m_cur.d));
      chk("mem_be", 64'(mem_be), 64'(m_cur.be));
      chk("ld_hit", 64'(ld_hit), 64'(ld_check && hit()));
      if (rst_n && mem_req && mem_ack) wlog.push_back('{mem_addr, mem_wdata, mem_be});
    end

  task automatic send(input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    st_valid = 1; st_sel = s; st_addr = a; st_data = d;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (st_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    st_valid = 0;
    chk("send_timeout", 64'(ok), 64'(1));
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (empty) begin ok = 1; break; end
    end
    chk("drain_timeout", 64'(ok), 64'(1));
  endtask

  initial begin
    run = 1;
    #12;
    chk("rst_req", 64'(mem_req), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_ready", 64'(st_ready), 64'(1));
    chk("rst_be", 64'(mem_be), 64'(0));
    @(posedge clk); #1;
    rst_n = 1;
    // byte stores across one word, memory always ready
    mem_ack = 1;
    wlog.delete();
    for (int i = 0; i < 4; i++) send(3'd0, 32'h100 + 32'(i), 32'h11223344);
    drain();
    chk("sb_count", 64'(wlog.size()), 64'(4));
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk("sb_addr", 64'(wlog[i].a), 64'(30'h40));
      chk("sb_be", 64'(wlog[i].be), 64'(4'b1000 >> i));
      chk("sb_data", 64'(wlog[i].d), 64'(32'h44444444));
    end
    // unaligned swl / swr
    wlog.delete();
    send(3'd3, 32'h201, 32'hAABBCCDD);
    send(3'd4, 32'h201, 32'hAABBCCDD);
    drain();
    chk("lr_count", 64'(wlog.size()), 64'(2));
    if (wlog.size() == 2) begin
      chk("swl_be", 64'(wlog[0].be), 64'(4'b0111));
      chk("swl_data", 64'(wlog[0].d), 64'(32'h00AABBCC));
      chk("swr_be", 64'(wlog[1].be), 64'(4'b1100));
      chk("swr_data", 64'(wlog[1].d), 64'(32'hCCDD0000));
    end
    // fill with ack held low, then drain back-to-back
    @(posedge clk); #1;
    mem_ack = 0;
    wlog.delete();
    for (int i = 0; i < 4; i++) send(3'd2, 32'h500 + 32'(4 * i), 32'hA0 + 32'(i));
    @(posedge clk); #1;
    st_valid = 1; st_sel = 3'd2; st_addr = 32'h510; st_data = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_ready", 64'(st_ready), 64'(0));
      chk("full_flag", 64'(full), 64'(1));
      chk("hold_addr", 64'(mem_addr), 64'(30'h140));
      chk("hold_data", 64'(mem_wdata), 64'(32'hA0));
    end
    @(posedge clk); #1;
    st_valid = 0;
    mem_ack = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_req", 64'(mem_req), 64'(1));
    end
    @(negedge clk);
    chk("b2b_empty", 64'(empty), 64'(1));
    chk("b2b_count", 64'(wlog.size()), 64'(4));
    for (int i = 0; i < 4 && i < wlog.size(); i++) chk("b2b_order", 64'(wlog[i].a), 64'(30'h140 + 30'(i)));
    // load hazard including the ack cycle
    @(posedge clk); #1;
    mem_ack = 0;
    send(3'd2, 32'h300, 32'h5555AAAA);
    @(posedge clk); #1;
    ld_check = 1; ld_addr = 32'h302;
    @(negedge clk);
    chk("hz_same_word", 64'(ld_hit), 64'(1));
    @(posedge clk); #1;
    ld_addr = 32'h304;
    @(negedge clk);
    chk("hz_next_word", 64'(ld_hit), 64'(0));
    @(posedge clk); #1;
    ld_addr = 32'h302; mem_ack = 1;
    @(negedge clk);
    chk("hz_ack_req", 64'(mem_req), 64'(1));
    chk("hz_ack_cycle", 64'(ld_hit), 64'(1));
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
    chk("hz_after_pop", 64'(ld_hit), 64'(0));
    @(posedge clk); #1;
    ld_check = 0;
    // asynchronous reset mid-transfer
    for (int i = 0; i < 3; i++) send(3'd2, 32'h700 + 32'(4 * i), 32'(i));
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("arst_req", 64'(mem_req), 64'(0));
    chk("arst_empty", 64'(empty), 64'(1));
    chk("arst_full", 64'(full), 64'(0));
    wlog.delete();
    @(posedge clk); #1;
    rst_n = 1; mem_ack = 1;
    repeat (10) @(negedge clk);
    chk("arst_nowrite", 64'(wlog.size()), 64'(0));
    // random traffic against the model
    repeat (3000) begin
      @(posedge clk); #1;
      st_valid = 1'($urandom_range(0, 1));
      st_sel = 3'($urandom_range(0, 7));
      st_addr = 32'h600 + 32'($urandom_range(0, 15));
      st_data = $urandom;
      ld_check = 1'($urandom_range(0, 1));
      ld_addr = 32'h600 + 32'($urandom_range(0, 15));
      mem_ack = $urandom_range(0, 3) != 0;
    end
    @(posedge clk); #1;
    st_valid = 0; ld_check = 0; mem_ack = 1;
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
